// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid activation scheduler.
package sigmoid_pkg;

    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned CNT_W       = 4;

    localparam logic [15:0] ONE_Q88  = 16'h0100;
    localparam logic [15:0] ZERO_Q88 = 16'h0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_CLEAR = 2'd0;
    localparam state_t ST_ARB   = 2'd1;
    localparam state_t ST_ISSUE = 2'd2;
    localparam state_t ST_WAIT  = 2'd3;

    // Round-robin pointer advance: one past the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sigmoid_sched_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_arbiter
    import sigmoid_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                                  req,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0]                                  grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]    idx,
    output logic                                                any
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!any && req[pos]) begin
                any        = 1'b1;
                idx        = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigmoid_sched.sv
// Shares one sigmoid unit among NUM_REQ requesters: arbitrate, issue, wait for
// the sticky ready (or time out), return the result, then flush the unit.
module sigmoid_sched
    import sigmoid_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*DW-1:0]   req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [DW-1:0]           rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    sig_done,
    output logic [DW-1:0]           sig_in,
    output logic                    sig_rst,
    input  logic                    sig_ready,
    input  logic [DW-1:0]           sig_out
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state,     state_d;
    logic [IW-1:0]      rr_ptr,    rr_ptr_d;
    logic [IW-1:0]      idx,       idx_d;
    logic [CNT_W-1:0]   wait_cnt,  wait_cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [DW-1:0]      rsp_data_d;
    logic               rsp_err_d;
    logic               busy_d;
    logic               sig_done_d;
    logic [DW-1:0]      sig_in_d;
    logic               sig_rst_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    // Next-state and next-output logic; every output is a registered copy.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        idx_d       = idx;
        wait_cnt_d  = wait_cnt;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        sig_done_d  = 1'b0;
        sig_in_d    = sig_in;
        sig_rst_d   = 1'b0;

        case (state)
            ST_CLEAR: begin
                state_d = ST_ARB;
            end
            ST_ARB: begin
                if (arb_any) begin
                    state_d  = ST_ISSUE;
                    gnt_d    = arb_grant;
                    idx_d    = arb_idx;
                    sig_in_d = req_data[arb_idx*DW +: DW];
                    rr_ptr_d = IW'(rr_next(32'(arb_idx), NUM_REQ));
                end
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT;
                sig_done_d = 1'b1;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (sig_ready) begin
                    state_d     = ST_CLEAR;
                    rsp_data_d  = sig_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << idx;
                    sig_rst_d   = 1'b1;
                end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    state_d     = ST_CLEAR;
                    rsp_data_d  = DW'(ZERO_Q88);
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << idx;
                    sig_rst_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                sig_rst_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_ARB);
    end

    // Reset lands in CLEAR so any stale ready in the sigmoid unit is flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            rr_ptr    <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= DW'(ZERO_Q88);
            rsp_err   <= 1'b0;
            busy      <= 1'b1;
            sig_done  <= 1'b0;
            sig_in    <= '0;
            sig_rst   <= 1'b1;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            idx       <= idx_d;
            wait_cnt  <= wait_cnt_d;
            gnt       <= gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
            sig_done  <= sig_done_d;
            sig_in    <= sig_in_d;
            sig_rst   <= sig_rst_d;
        end
    end

endmodule

// File: tb/tb_sigmoid_sched.sv
// Scoreboard bench for sigmoid_sched with a behavioural sticky-ready sigmoid unit.
module tb_sigmoid_sched;
    import sigmoid_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 15;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic [NR-1:0]     req      = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              sig_done;
    logic [DW-1:0]     sig_in;
    logic              sig_rst;
    logic              sig_ready;
    logic [DW-1:0]     sig_out;

    always #5 clk = ~clk;

    sigmoid_sched #(.NUM_REQ(NR), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .sig_done  (sig_done),
        .sig_in    (sig_in),
        .sig_rst   (sig_rst),
        .sig_ready (sig_ready),
        .sig_out   (sig_out)
    );

    // Hard-sigmoid reference of the external unit, Q8.8 in and out.
    function automatic logic [15:0] sig_f(input logic [15:0] x);
        if (!x[15] && x >= 16'h0200) return ONE_Q88;
        if (x[15] && x <= 16'hFE00)  return ZERO_Q88;
        return 16'h0080 + {{2{x[15]}}, x[15:2]};
    endfunction

    // Sigmoid unit: samples done, raises a sticky ready one cycle later.
    logic          m_rdy = 1'b0;
    logic [DW-1:0] m_out = '0;
    logic          stuck = 1'b0;
    logic          mute  = 1'b0;

    always @(posedge clk) begin
        if (sig_rst) begin
            m_rdy <= 1'b0;
        end else if (sig_done && !mute) begin
            m_rdy <= 1'b1;
            m_out <= sig_f(sig_in);
        end
    end

    assign sig_ready = stuck | m_rdy;
    assign sig_out   = m_out;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        gnt_q[$];
    exp_t        rsp_q[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          gnt_cyc    = 0;
    logic [15:0] last_op    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (reset) begin
            if (gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt), 32'h0);
                end else begin
                    e = gnt_q.pop_front();
                    check("gnt", 32'(gnt), 32'(1) << e.idx);
                    gnt_cyc = cyc;
                    last_op = e.data;
                end
            end
            if (sig_done) begin
                check("sig_in", 32'(sig_in), 32'(last_op));
                check("done_lat", 32'(cyc - gnt_cyc), 32'd1);
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_lat", 32'(cyc - gnt_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_slice(input int i, input logic [15:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic push_op(input int i, input logic [15:0] d, input bit tmo, input bit aborted);
        exp_t e;
        e.idx  = i;
        e.data = d;
        e.err  = tmo;
        e.lat  = tmo ? int'(TO) + 2 : 3;
        gnt_q.push_back(e);
        if (!aborted) begin
            e.data = tmo ? ZERO_Q88 : sig_f(d);
            rsp_q.push_back(e);
        end
    endtask

    task automatic wait_gnts(input int n, input int budget);
        int seen = 0;
        while (seen < n && budget > 0) begin
            tick();
            if (gnt != '0) seen++;
            budget--;
        end
        if (seen < n) check("gnt_timeout", 32'(seen), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        while ((gnt_q.size() != 0 || rsp_q.size() != 0 || busy) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_timeout", 32'(gnt_q.size() + rsp_q.size()), 32'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"},       32'(gnt),       32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        check({tag, "_sig_done"},  32'(sig_done),  32'h0);
        check({tag, "_sig_in"},    32'(sig_in),    32'h0);
        check({tag, "_sig_rst"},   32'(sig_rst),   32'h1);
        check({tag, "_busy"},      32'(busy),      32'h1);
    endtask

    initial begin
        int rst_cycles;
        int b;

        // Reset with ready stuck high: one flush cycle, then idle ARB.
        stuck = 1'b1;
        tick(3);
        check_reset_vals("rst");
        reset = 1'b1;
        rst_cycles = 0;
        repeat (5) begin
            @(negedge clk);
            if (sig_rst) rst_cycles++;
        end
        check("clear_len", 32'(rst_cycles), 32'd1);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_gnt", 32'(gnt), 32'h0);
        tick();
        stuck = 1'b0;

        // All four requesting continuously from rr_ptr=0.
        set_slice(0, 16'h0100);
        set_slice(1, 16'hFF00);
        set_slice(2, 16'h0000);
        set_slice(3, 16'h7F00);
        push_op(0, 16'h0100, 1'b0, 1'b0);
        push_op(1, 16'hFF00, 1'b0, 1'b0);
        push_op(2, 16'h0000, 1'b0, 1'b0);
        push_op(3, 16'h7F00, 1'b0, 1'b0);
        push_op(0, 16'h0100, 1'b0, 1'b0);
        req = 4'b1111;
        wait_gnts(5, 60);
        req = '0;
        wait_idle(40);

        // Fairness: req0 and req3 held with rr_ptr=1.
        set_slice(0, 16'h8000);
        set_slice(3, 16'h0040);
        push_op(3, 16'h0040, 1'b0, 1'b0);
        push_op(0, 16'h8000, 1'b0, 1'b0);
        push_op(3, 16'h0040, 1'b0, 1'b0);
        req = 4'b1001;
        wait_gnts(3, 40);
        req = '0;
        wait_idle(40);

        // Timeout: unit never raises ready.
        mute = 1'b1;
        set_slice(1, 16'h1234);
        push_op(1, 16'h1234, 1'b1, 1'b0);
        req = 4'b0010;
        wait_gnts(1, 10);
        req = '0;
        b = 40;
        while (rsp_valid == '0 && b > 0) begin
            tick();
            b--;
        end
        check("tmo_seen", 32'(b != 0), 32'h1);
        check("tmo_sig_rst", 32'(sig_rst), 32'h1);
        check("tmo_busy", 32'(busy), 32'h1);
        tick();
        check("tmo_recover_rst", 32'(sig_rst), 32'h0);
        check("tmo_recover_busy", 32'(busy), 32'h0);
        mute = 1'b0;
        wait_idle(40);

        // Single request, latency checked directly.
        set_slice(2, 16'h7F00);
        push_op(2, 16'h7F00, 1'b0, 1'b0);
        req = 4'b0100;
        tick();
        check("req_to_gnt", 32'(gnt), 32'h4);
        req = '0;
        wait_idle(40);
        tick(3);
        check("rsp_hold", 32'(rsp_data), 32'(ONE_Q88));

        // Reset in WAIT abandons the operation and rewinds rr_ptr.
        mute = 1'b1;
        set_slice(1, 16'h0055);
        push_op(1, 16'h0055, 1'b0, 1'b1);
        req = 4'b0010;
        wait_gnts(1, 10);
        req = '0;
        tick(3);
        check("pre_abort_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        tick(2);
        reset = 1'b1;
        mute  = 1'b0;
        b = 10;
        while (busy && b > 0) begin
            tick();
            b--;
        end
        check("abort_recover", 32'(busy), 32'h0);
        set_slice(0, 16'h0100);
        push_op(0, 16'h0100, 1'b0, 1'b0);
        req = 4'b1111;
        wait_gnts(1, 10);
        req = '0;
        wait_idle(40);
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
